// File: rtl/twiddle_fetch.sv
// twiddle_fetch: twiddle ROM read controller for an R2^2SDF stage; aligns ROM word and sample with a valid flag.
// Define TWIDDLE_INV_EN to add i_inverse, which selects conjugate (IFFT) twiddles.
module twiddle_fetch #(
  parameter int DWIDTH        = 32,
  parameter int N_LOG         = 4,
  parameter int ROM_DEPTH_LOG = 9
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_valid,
  input  logic                     i_sync,
  input  logic [DWIDTH-1:0]        i_data,
`ifdef TWIDDLE_INV_EN
  input  logic                     i_inverse,
`endif
  output logic [ROM_DEPTH_LOG-1:0] o_rom_addr,
  input  logic [DWIDTH-1:0]        i_rom_data,
  output logic                     o_valid,
  output logic [DWIDTH-1:0]        o_twiddle,
  output logic [DWIDTH-1:0]        o_data,
  output logic                     o_last
);
  logic [N_LOG-1:0]         n_q, n_use, e;
  logic [1:0]               q;
  logic [N_LOG-3:0]         k;
  logic [ROM_DEPTH_LOG-1:0] a, a_d;
  logic [DWIDTH-1:0]        d1_q;
  logic                     v1_q, l1_q;
  // quadrant multiplier {0,2,1,3} is the quadrant index with its bits swapped
  always_comb begin
    n_use = i_sync ? '0 : n_q;
    q     = n_use[N_LOG-1:N_LOG-2];
    k     = n_use[N_LOG-3:0];
    e     = N_LOG'(k) * N_LOG'({q[0], q[1]});
    a     = ROM_DEPTH_LOG'(e) << (ROM_DEPTH_LOG - N_LOG);
`ifdef TWIDDLE_INV_EN
    a_d   = i_inverse ? -a : a;
`else
    a_d   = a;
`endif
  end
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) begin
      n_q        <= '0;
      v1_q       <= 1'b0;
      l1_q       <= 1'b0;
      d1_q       <= '0;
      o_rom_addr <= '0;
      o_twiddle  <= '0;
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_last     <= 1'b0;
    end else begin
      if (i_valid) begin
        n_q        <= n_use + N_LOG'(1);
        o_rom_addr <= a_d;
        d1_q       <= i_data;
        l1_q       <= &n_use;
      end else if (i_sync) begin
        n_q        <= '0;
      end
      v1_q <= i_valid;
      if (v1_q) begin
        o_twiddle <= i_rom_data;
        o_data    <= d1_q;
      end
      o_valid <= v1_q;
      o_last  <= v1_q & l1_q;
    end
endmodule

// File: tb/tb_twiddle_fetch.sv
// tb_twiddle_fetch: directed bench with a sample-level reference model for twiddle_fetch.
module tb_twiddle_fetch;
  localparam int DW = 32, NL = 4, RL = 9, NN = 16, RD = 512;
  logic clk = 0, rstn = 0, vin = 0, sin = 0, inv = 0;
  logic [DW-1:0] din = '0, rom_d, tw, od;
  logic [RL-1:0] addr;
  logic ov, ol;
  typedef struct {bit v; bit l; int a; logic [DW-1:0] d;} ent_t;
  ent_t p0, p1;
  int mn, ea, checks, errors, outcnt, lastcnt, stepno, first_v;
  bit ev, el;
  logic [DW-1:0] etw, ed;
  int last_pos[$];
  int lit[16] = '{0, 0, 0, 0, 0, 64, 128, 192, 0, 32, 64, 96, 0, 96, 192, 288};

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom(input logic [RL-1:0] a);
    return {7'd0, a, 16'hC3A5 ^ {7'd0, a}};
  endfunction
  assign rom_d = rom(addr);

  twiddle_fetch #(.DWIDTH(DW), .N_LOG(NL), .ROM_DEPTH_LOG(RL)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_valid(vin), .i_sync(sin), .i_data(din),
`ifdef TWIDDLE_INV_EN
    .i_inverse(inv),
`endif
    .o_rom_addr(addr), .i_rom_data(rom_d), .o_valid(ov), .o_twiddle(tw),
    .o_data(od), .o_last(ol));

  function automatic int model_addr(input int nu, input bit iv);
    int qq, kk, m, a;
    qq = nu / (NN / 4);
    kk = nu % (NN / 4);
    m  = (qq == 1) ? 2 : (qq == 2) ? 1 : qq;
    a  = kk * m * (RD / NN);
    return iv ? (RD - a) % RD : a;
  endfunction

  function automatic void chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    mn = 0; ea = 0; ev = 0; el = 0; etw = '0; ed = '0;
    p0 = '{default: '0};
    p1 = '{default: '0};
  endtask

  task automatic begin_test();
    outcnt = 0; lastcnt = 0; stepno = 0; first_v = -1;
    last_pos.delete();
  endtask

  function automatic int pos(input int i);
    return (last_pos.size() > i) ? last_pos[i] : -1;
  endfunction

  task automatic step(input bit v, input bit s, input logic [DW-1:0] d);
    ent_t e;
    int nu;
    @(posedge clk);
    #1;
    if (p0.v) ea = p0.a;
    ev = p1.v;
    el = p1.v && p1.l;
    if (p1.v) begin
      etw = rom(RL'(p1.a));
      ed  = p1.d;
    end
    p1 = p0;
    e = '{default: '0};
    if (v) begin
      nu  = s ? 0 : mn;
      mn  = (nu + 1) % NN;
      e.v = 1;
      e.l = (nu == NN - 1);
      e.a = model_addr(nu, inv);
      e.d = d;
    end else if (s) mn = 0;
    p0 = e;
    vin = v; sin = s; din = d;
    @(negedge clk);
    stepno++;
    chk("o_valid", 32'(ov), 32'(ev));
    chk("o_last", 32'(ol), 32'(el));
    chk("o_rom_addr", 32'(addr), 32'(ea));
    chk("o_twiddle", tw, etw);
    chk("o_data", od, ed);
    if (ov) begin
      outcnt++;
      if (first_v < 0) first_v = stepno;
      if (ol) begin
        lastcnt++;
        last_pos.push_back(outcnt);
      end
    end
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_valid"}, 32'(ov), 0);
    chk({nm, "_last"}, 32'(ol), 0);
    chk({nm, "_addr"}, 32'(addr), 0);
    chk({nm, "_twiddle"}, tw, 0);
    chk({nm, "_data"}, od, 0);
  endtask

  int pat[5] = '{1, 0, 0, 1, 1};

  initial begin
    checks = 0; errors = 0;
    model_reset();
    begin_test();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1 rstn = 1;

    begin_test();
    for (int i = 0; i < 16; i++) begin
      step(1, i == 0, 32'hA000_0000 + i);
      if (i > 0) chk($sformatf("t1_addr%0d", i - 1), 32'(addr), 32'(lit[i - 1]));
    end
    step(0, 0, '0);
    chk("t1_addr15", 32'(addr), 32'(lit[15]));
    step(0, 0, '0);
    step(0, 0, '0);
    chk("t1_latency", 32'(first_v), 3);
    chk("t1_last_count", 32'(lastcnt), 1);
    chk("t1_last_pos", 32'(pos(0)), 16);

    begin_test();
    for (int i = 0; i < 40; i++) step(1, i == 0, 32'hB000_0000 + 3 * i);
    repeat (3) step(0, 0, '0);
    chk("t2_last_count", 32'(lastcnt), 2);
    chk("t2_last_pos0", 32'(pos(0)), 16);
    chk("t2_last_pos1", 32'(pos(1)), 32);

    begin_test();
    for (int i = 0; i < 5; i++) step(pat[i] == 1, 0, 32'hC000_0000 + i);
    repeat (3) step(0, 0, '0);
    chk("t3_out_count", 32'(outcnt), 3);
    chk("t3_latency", 32'(first_v), 3);

    begin_test();
    for (int i = 0; i < 9; i++) step(1, i == 0, 32'hD000_0000 + i);
    for (int i = 0; i < 16; i++) begin
      step(1, i == 0, 32'hD100_0000 + i);
      if (i == 1) chk("t4_sync_addr", 32'(addr), 0);
    end
    repeat (3) step(0, 0, '0);
    chk("t4_last_count", 32'(lastcnt), 1);
    chk("t4_last_pos", 32'(pos(0)), 25);

    for (int i = 0; i < 8; i++) step(1, i == 0, 32'hE000_0000 + i);
    @(posedge clk);
    #2;
    vin = 0; sin = 0;
    chk("t5_pre_valid", 32'(ov), 1);
    rstn = 0;
    #1;
    check_zero("t5_async");
    model_reset();
    repeat (2) @(posedge clk);
    #1 rstn = 1;
    begin_test();
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 32'hE100_0000 + i);
      if (i == 1) chk("t5_first_addr", 32'(addr), 0);
      if (i == 6) chk("t5_n5_addr", 32'(addr), 64);
    end
    repeat (3) step(0, 0, '0);
    chk("t5_last_count", 32'(lastcnt), 1);
    chk("t5_last_pos", 32'(pos(0)), 16);

`ifdef TWIDDLE_INV_EN
    inv = 1;
    for (int i = 0; i < 14; i++) begin
      step(1, i == 0, 32'hF000_0000 + i);
      if (i == 1) chk("inv_n0_addr", 32'(addr), 0);
    end
    step(0, 0, '0);
    chk("inv_n13_addr", 32'(addr), 416);
    inv = 0;
    repeat (2) step(0, 0, '0);
`endif

    repeat (2) step(0, 0, '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
